// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - parity-mode encodings as presented on the parity_mode input
//   - transmitter FSM state type
//   - small helpers for parity selection and parity bit generation
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Mode 3 is an alias for "no parity", so only the two explicit codes enable it.
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // acc is the XOR of all data bits; odd parity transmits its complement.
   function automatic logic parity_bit(input logic acc, input logic [1:0] mode);
      return (mode == PAR_ODD) ? ~acc : acc;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with registered status flags and a registered head word.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (flushes the FIFO)
//   i_wr_en       write request, ignored while full (no write-through)
//   i_wr_data     word to write
//   i_rd_en       pop request, ignored while empty
//   o_rd_data     registered copy of the current head entry
//   o_full        registered full flag
//   o_empty       registered empty flag
//   o_level       registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_wr_en,
   input  logic [WIDTH-1:0]               i_wr_data,
   input  logic                           i_rd_en,
   output logic [WIDTH-1:0]               o_rd_data,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_full;
   logic             r_empty;
   logic [WIDTH-1:0] r_head;

   logic             w_wr;
   logic             w_rd;
   logic [AW-1:0]    w_rd_ptr_nxt;
   logic [LW-1:0]    w_level_nxt;

   // Qualified write/pop strobes and the next pointer/level values.
   always_comb begin
      w_wr         = i_wr_en && !r_full;
      w_rd         = i_rd_en && !r_empty;
      w_rd_ptr_nxt = r_rd_ptr;
      if (w_rd) begin
         w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
      end else begin
         w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_wr, w_rd})
         2'b10:   w_level_nxt = r_level + LVL_ONE;
         2'b01:   w_level_nxt = r_level - LVL_ONE;
         default: w_level_nxt = r_level;
      endcase
   end

   // Storage array; pointers alone define validity, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers, occupancy, flags and the head register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_level  <= {LW{1'b0}};
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_head   <= {WIDTH{1'b0}};
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         r_full   <= (w_level_nxt == LVL_FULL);
         r_empty  <= (w_level_nxt == {LW{1'b0}});
         // When the word being written becomes the new head, bypass the array.
         if (w_wr && (w_rd_ptr_nxt == r_wr_ptr)) begin
            r_head <= i_wr_data;
         end else begin
            r_head <= r_mem[w_rd_ptr_nxt];
         end
      end
   end

   assign o_rd_data = r_head;
   assign o_full    = r_full;
   assign o_empty   = r_empty;
   assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// Buffered UART transmitter. Words arrive on a valid/ready stream, are queued
// in uart_sync_fifo and sent LSB first as start, data, optional parity and one
// or two stop bits. Frame settings are captured when a word is popped, and
// frames follow each other with no idle gap while data and enable are present.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        allows new frames to start (a running frame always finishes)
//   baud_div      clock cycles per bit, 0 behaves as 1
//   parity_mode   0/3 none, 1 even, 2 odd
//   two_stop      1 selects two stop bits
//   s_tdata       input word
//   s_tvalid      input word valid
//   s_tready      input ready (FIFO not full)
//   uart_tx       registered serial line, idles high
//   busy          high while a frame is in progress
//   tx_done       one-cycle pulse on the last cycle of each frame
//   fifo_level    FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
)
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic [DIV_WIDTH-1:0]               baud_div,
   input  logic [1:0]                         parity_mode,
   input  logic                               two_stop,
   input  logic [DATA_BITS-1:0]               s_tdata,
   input  logic                               s_tvalid,
   output logic                               s_tready,
   output logic                               uart_tx,
   output logic                               busy,
   output logic                               tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

   localparam int IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0]        LAST_IDX = IW'(DATA_BITS-1);
   localparam logic [IW-1:0]        IDX_ONE  = IW'(1'b1);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1'b1);
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};

   uart_state_t            r_state;
   logic [DIV_WIDTH-1:0]   r_cnt;
   logic [DIV_WIDTH-1:0]   r_div;
   logic [DATA_BITS-1:0]   r_shift;
   logic [IW-1:0]          r_idx;
   logic [1:0]             r_pmode;
   logic                   r_two_stop;
   logic                   r_stop2;
   logic                   r_par;
   logic                   r_tx;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_full;
   logic                   w_empty;
   logic [DATA_BITS-1:0]   w_head;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_bit_end;
   logic                   w_final_stop;
   logic [DIV_WIDTH-1:0]   w_div_eff;

   // Push/pop strobes and bit-period decode; a pop happens from IDLE or on the
   // last cycle of the final stop bit, which is what makes frames back-to-back.
   always_comb begin
      w_push       = s_tvalid && !w_full;
      w_bit_end    = (r_cnt == DIV_ZERO);
      w_final_stop = !r_two_stop || r_stop2;
      if (baud_div == DIV_ZERO) begin
         w_div_eff = DIV_ONE;
      end else begin
         w_div_eff = baud_div;
      end
      w_pop = 1'b0;
      case (r_state)
         ST_IDLE: w_pop = enable && !w_empty;
         ST_STOP: begin
            if (w_bit_end && w_final_stop) begin
               w_pop = enable && !w_empty;
            end else begin
               w_pop = 1'b0;
            end
         end
         default: w_pop = 1'b0;
      endcase
   end

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_push),
      .i_wr_data (s_tdata),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (fifo_level)
   );

   // Transmit FSM with bit counter, shift register and parity accumulator.
   // tx_done is set one cycle ahead so that it lands on the final stop cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= DIV_ZERO;
         r_div      <= DIV_ONE;
         r_shift    <= {DATA_BITS{1'b0}};
         r_idx      <= {IW{1'b0}};
         r_pmode    <= PAR_NONE;
         r_two_stop <= 1'b0;
         r_stop2    <= 1'b0;
         r_par      <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state <= ST_DATA;
                  r_tx    <= r_shift[0];
                  r_cnt   <= r_div - DIV_ONE;
                  r_idx   <= {IW{1'b0}};
                  r_par   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - DIV_ONE;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= r_div - DIV_ONE;
                  r_par <= r_par ^ r_shift[0];
                  if (r_idx == LAST_IDX) begin
                     if (parity_enabled(r_pmode)) begin
                        r_state <= ST_PARITY;
                        r_tx    <= parity_bit(r_par ^ r_shift[0], r_pmode);
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                        r_stop2 <= 1'b0;
                        r_done  <= (r_div == DIV_ONE) && !r_two_stop;
                     end
                  end else begin
                     r_idx   <= r_idx + IDX_ONE;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt - DIV_ONE;
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
                  r_stop2 <= 1'b0;
                  r_cnt   <= r_div - DIV_ONE;
                  r_done  <= (r_div == DIV_ONE) && !r_two_stop;
               end else begin
                  r_cnt <= r_cnt - DIV_ONE;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  if (!w_final_stop) begin
                     r_stop2 <= 1'b1;
                     r_cnt   <= r_div - DIV_ONE;
                     r_done  <= (r_div == DIV_ONE);
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_cnt  <= r_cnt - DIV_ONE;
                  r_done <= (r_cnt == DIV_ONE) && w_final_stop;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_tx    <= 1'b1;
            end
         endcase
         // A pop overrides the per-state decision: load the word, capture the
         // frame settings and begin the start bit on the next cycle.
         if (w_pop) begin
            r_state    <= ST_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_shift    <= w_head;
            r_div      <= w_div_eff;
            r_cnt      <= w_div_eff - DIV_ONE;
            r_pmode    <= parity_mode;
            r_two_stop <= two_stop;
            r_stop2    <= 1'b0;
         end
      end
   end

   assign s_tready = ~w_full;
   assign uart_tx  = r_tx;
   assign busy     = r_busy;
   assign tx_done  = r_done;

endmodule
